// File: rtl/seg_scan_driver.sv
// seg_scan_driver: four-digit common-anode seven-segment scanner.
// At each frame start it captures the digits, decimal points and blank flags.
// It then lights one anode per slot, with a dead-time gap at the start of
// every slot so the previous digit cannot ghost onto the next one.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] DP,
  input  logic [3:0] Blank,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic       FrameTick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_dig_q, snap_dig_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic [3:0]       snap_blank_q, snap_blank_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick_q, tick_d;

  logic             frame_start;
  logic             slot_end;
  logic             dark;
  logic [3:0]       cur_dig;

  // Next-state for the scan counters, snapshot and display outputs.
  // The output decode reads the snapshot's next value so the frame just
  // captured is already shown on its very first cycle.
  always_comb begin
    frame_start  = (cnt_q == '0) && (idx_q == 2'd0);
    slot_end     = (cnt_q == CNT_MAX);

    snap_dig_d   = snap_dig_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    if (frame_start) begin
      snap_dig_d   = {D3, D2, D1, D0};
      snap_dp_d    = DP;
      snap_blank_d = Blank;
    end

    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d = slot_end ? idx_q + 2'd1 : idx_q;

    cur_dig = snap_dig_d[{idx_q, 2'b00} +: 4];
    dark    = (int'(cnt_q) < DEAD_CYCLES) || snap_blank_d[idx_q];

    an_d   = 4'b1111;
    seg_d  = 7'b1111111;
    dp_d   = 1'b1;
    if (!dark) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex7(cur_dig);
      dp_d  = ~snap_dp_d[idx_q];
    end

    tick_d = (idx_q == 2'd3) && slot_end;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      snap_dig_q   <= 16'h0000;
      snap_dp_q    <= 4'b0000;
      snap_blank_q <= 4'b1111;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_dig_q   <= snap_dig_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      tick_q       <= tick_d;
    end
  end

  assign An        = an_q;
  assign Seg       = seg_q;
  assign Dp        = dp_q;
  assign FrameTick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed testbench for seg_scan_driver: one instance with an 8-cycle slot
// and 2 dead cycles, and one with a 2-cycle slot and no dead time.
module tb_seg_scan_driver;

  localparam int RA = 8;
  localparam int DA = 2;
  localparam int FA = 4 * RA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // DUT A
  logic       a_rst_n;
  logic [3:0] a_d [4];
  logic [3:0] a_dpi, a_bl;
  logic [3:0] a_an;
  logic [6:0] a_seg;
  logic       a_dp, a_ft;

  seg_scan_driver #(.REFRESH_DIV(RA), .DEAD_CYCLES(DA)) dut_a (
    .Clk(clk), .Reset_n(a_rst_n),
    .D0(a_d[0]), .D1(a_d[1]), .D2(a_d[2]), .D3(a_d[3]),
    .DP(a_dpi), .Blank(a_bl),
    .An(a_an), .Seg(a_seg), .Dp(a_dp), .FrameTick(a_ft));

  // DUT B
  logic       b_rst_n;
  logic [3:0] b_an;
  logic [6:0] b_seg;
  logic       b_dp, b_ft;

  seg_scan_driver #(.REFRESH_DIV(2), .DEAD_CYCLES(0)) dut_b (
    .Clk(clk), .Reset_n(b_rst_n),
    .D0(4'h0), .D1(4'h1), .D2(4'h2), .D3(4'h3),
    .DP(4'b0000), .Blank(4'b0000),
    .An(b_an), .Seg(b_seg), .Dp(b_dp), .FrameTick(b_ft));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected snapshot and frame position for DUT A
  int         pos = 0;
  logic [3:0] m_d [4];
  logic [3:0] m_dp, m_bl;

  task automatic step_a();
    int         slot, c;
    logic       lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (pos == 0) begin
      for (int i = 0; i < 4; i++) m_d[i] = a_d[i];
      m_dp = a_dpi;
      m_bl = a_bl;
    end
    slot  = pos / RA;
    c     = pos % RA;
    lit   = (c >= DA) && !m_bl[slot];
    e_an  = 4'b1111;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    if (lit) begin
      e_an       = 4'b1111;
      e_an[slot] = 1'b0;
      e_seg      = hex_tab[m_d[slot]];
      e_dp       = ~m_dp[slot];
    end
    tick();
    chk("a_an", {28'd0, a_an}, {28'd0, e_an});
    chk("a_seg", {25'd0, a_seg}, {25'd0, e_seg});
    chk("a_dp", {31'd0, a_dp}, {31'd0, e_dp});
    chk("a_ft", {31'd0, a_ft}, (pos == FA - 1) ? 32'd1 : 32'd0);
    chk("a_onehot", ($countones(~a_an) <= 1) ? 32'd1 : 32'd0, 32'd1);
    pos = (pos + 1) % FA;
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_an"}, {28'd0, a_an}, 32'hF);
    chk({tag, "_seg"}, {25'd0, a_seg}, 32'h7F);
    chk({tag, "_dp"}, {31'd0, a_dp}, 32'd1);
    chk({tag, "_ft"}, {31'd0, a_ft}, 32'd0);
  endtask

  // One frame after reset release with digits 1,2,3,4; edges numbered from 1
  task automatic first_frame(input string tag);
    for (int k = 1; k <= FA; k++) begin
      step_a();
      if (k == 2) chk({tag, "_e2_an"}, {28'd0, a_an}, 32'hF);
      if (k == 3) begin
        chk({tag, "_e3_an"}, {28'd0, a_an}, 32'hE);
        chk({tag, "_e3_seg"}, {25'd0, a_seg}, {25'd0, 7'b1111001});
      end
      if (k == 8) chk({tag, "_e8_an"}, {28'd0, a_an}, 32'hE);
      if (k == 9 || k == 10) chk({tag, "_e9_an"}, {28'd0, a_an}, 32'hF);
      if (k == 11) begin
        chk({tag, "_e11_an"}, {28'd0, a_an}, 32'hD);
        chk({tag, "_e11_seg"}, {25'd0, a_seg}, {25'd0, 7'b0100100});
      end
      if (k == 31) chk({tag, "_e31_ft"}, {31'd0, a_ft}, 32'd0);
      if (k == 32) chk({tag, "_e32_ft"}, {31'd0, a_ft}, 32'd1);
    end
  endtask

  initial begin
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    for (int i = 0; i < 4; i++) a_d[i] = 4'h0;
    a_dpi = 4'b0000;
    a_bl  = 4'b0000;
    repeat (3) tick();
    check_reset_a("rst");
    chk("b_rst_an", {28'd0, b_an}, 32'hF);
    chk("b_rst_ft", {31'd0, b_ft}, 32'd0);

    // Reset release and first frame
    a_d[0] = 4'h1; a_d[1] = 4'h2; a_d[2] = 4'h3; a_d[3] = 4'h4;
    a_rst_n = 1'b1;
    pos = 0;
    first_frame("ff");

    // Hex sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      a_d[0] = 4'(v);
      for (int k = 0; k < FA; k++) begin
        step_a();
        if (k == DA) chk("hex_d0", {25'd0, a_seg}, {25'd0, hex_tab[v]});
      end
    end

    // Snapshot coherence: D2 changes from 5 to A during slot 1
    a_d[2] = 4'h5;
    for (int k = 0; k < FA; k++) begin
      if (k == RA + 3) a_d[2] = 4'hA;
      step_a();
      if (k == 2 * RA + DA) chk("coh_old", {25'd0, a_seg}, {25'd0, 7'b0010010});
    end
    for (int k = 0; k < FA; k++) begin
      step_a();
      if (k == 2 * RA + DA) chk("coh_new", {25'd0, a_seg}, {25'd0, 7'b0001000});
    end

    // Blank on digit 2, decimal point on digit 0
    a_bl  = 4'b0100;
    a_dpi = 4'b0001;
    for (int k = 0; k < FA; k++) begin
      step_a();
      if (k / RA == 2) chk("blank_an2", {31'd0, a_an[2]}, 32'd1);
      chk("dp_slot0", {31'd0, a_dp}, (k < RA && k >= DA) ? 32'd0 : 32'd1);
    end

    // Mid-frame reset during slot 2
    a_bl  = 4'b0000;
    a_dpi = 4'b0000;
    a_d[0] = 4'h1; a_d[1] = 4'h2; a_d[2] = 4'h3; a_d[3] = 4'h4;
    while (pos != 2 * RA + 4) step_a();
    a_rst_n = 1'b0;
    tick();
    check_reset_a("mid_rst");
    a_rst_n = 1'b1;
    pos = 0;
    first_frame("mr");

    // Zero dead time, two-cycle slots
    b_rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      logic [3:0] e_an;
      int         s;
      tick();
      s = ((k - 1) / 2) % 4;
      e_an = 4'b1111;
      e_an[s] = 1'b0;
      chk("b_an", {28'd0, b_an}, {28'd0, e_an});
      chk("b_seg", {25'd0, b_seg}, {25'd0, hex_tab[s]});
      chk("b_ft", {31'd0, b_ft}, (k % 8 == 0) ? 32'd1 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
